// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak pad10*1 padder: lane width,
// domain modes, their suffix bytes and the final padding bit.
package keccak_pkg;

    localparam int w = 64;

    typedef enum logic [1:0] {
        MODE_KECCAK = 2'd0,
        MODE_SHA3   = 2'd1,
        MODE_SHAKE  = 2'd2,
        MODE_RSVD   = 2'd3
    } pad_mode_t;

    localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
    localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE  = 8'h1F;
    localparam logic [7:0] PAD_LAST      = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_PAD   = 2'd2,
        ST_FLUSH = 2'd3
    } pad_state_t;

    // The reserved mode encoding falls back to the SHA3 suffix.
    function automatic logic [7:0] suffix_of(input logic [1:0] m);
        case (pad_mode_t'(m))
            MODE_KECCAK: return SUFFIX_KECCAK;
            MODE_SHAKE:  return SUFFIX_SHAKE;
            default:     return SUFFIX_SHA3;
        endcase
    endfunction

endpackage

// File: rtl/counter_n.sv
// Modulo-N up counter with synchronous clear; tracks the lane index
// inside the current rate block.
module counter_n #(
    parameter int N  = 17,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == CW'(N - 1)) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/keccak_padder.sv
// Streaming pad10*1 padder: passes message lanes through, merges the domain
// suffix and final 0x80 bit, and emits padding lanes up to a full rate block.
module keccak_padder
    import keccak_pkg::*;
#(
    parameter int W          = w,
    parameter int RATE_LANES = 17,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] msg_len,
    input  logic [1:0]           mode,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last_in_block,
    output logic                 out_last,
    output logic                 busy
);

    localparam int B     = W / 8;
    localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

    // Handshakes: a lane moves on a rising edge where valid && ready; valid and
    // data are held steady until that edge, and ready never depends on valid.

    pad_state_t           state, state_next;
    logic [LEN_WIDTH-1:0] bytes_left, bytes_left_next;
    logic                 suffix_done, suffix_done_next;
    logic [7:0]           suffix, suffix_next;
    logic [IDX_W-1:0]     lane_idx;
    logic                 lane_end;
    logic                 can_load;
    logic                 load;
    logic [W-1:0]         gen_data;
    logic                 gen_last;

    counter_n #(.N(RATE_LANES), .CW(IDX_W)) u_lane_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE && start),
        .inc   (load),
        .count (lane_idx)
    );

    assign lane_end = (lane_idx == IDX_W'(RATE_LANES - 1));
    assign can_load = !out_valid || out_ready;
    assign in_ready = (state == ST_DATA) && can_load;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_next       = state;
        bytes_left_next  = bytes_left;
        suffix_done_next = suffix_done;
        suffix_next      = suffix;
        load             = 1'b0;
        gen_data         = '0;
        gen_last         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    bytes_left_next  = msg_len;
                    suffix_done_next = 1'b0;
                    suffix_next      = suffix_of(mode);
                    state_next       = (msg_len != '0) ? ST_DATA : ST_PAD;
                end
            end
            ST_DATA: begin
                if (in_valid && can_load) begin
                    load = 1'b1;
                    if (bytes_left > LEN_WIDTH'(B)) begin
                        gen_data        = in_data;
                        bytes_left_next = bytes_left - LEN_WIDTH'(B);
                    end else if (bytes_left == LEN_WIDTH'(B)) begin
                        gen_data        = in_data;
                        bytes_left_next = '0;
                        state_next      = ST_PAD;
                    end else begin
                        // Partial lane: keep live bytes, drop the suffix right after them.
                        for (int b = 0; b < B; b++) begin
                            if (LEN_WIDTH'(b) < bytes_left)
                                gen_data[8*b +: 8] = in_data[8*b +: 8];
                            else if (LEN_WIDTH'(b) == bytes_left)
                                gen_data[8*b +: 8] = suffix;
                        end
                        bytes_left_next  = '0;
                        suffix_done_next = 1'b1;
                        state_next       = lane_end ? ST_FLUSH : ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (can_load) begin
                    load = 1'b1;
                    if (!suffix_done) begin
                        gen_data[7:0]    = suffix;
                        suffix_done_next = 1'b1;
                    end
                    if (lane_end)
                        state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_valid && out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Closing lane of the padded message carries the final pad bit.
        if (load && lane_end && suffix_done_next) begin
            gen_data[W-1 -: 8] = gen_data[W-1 -: 8] | PAD_LAST;
            gen_last           = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= ST_IDLE;
            bytes_left        <= '0;
            suffix_done       <= 1'b0;
            suffix            <= '0;
            out_data          <= '0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            out_last_in_block <= 1'b0;
        end else begin
            state       <= state_next;
            bytes_left  <= bytes_left_next;
            suffix_done <= suffix_done_next;
            suffix      <= suffix_next;
            if (load) begin
                out_data          <= gen_data;
                out_valid         <= 1'b1;
                out_last          <= gen_last;
                out_last_in_block <= lane_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder (W=64, RATE_LANES=17): byte-level pad10*1
// reference model, hand-computed lane checks, stall and mid-run reset checks.
module tb_keccak_padder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] msg_len;
    logic [1:0]  mode;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last_in_block;
    logic        out_last;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_consumed;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic        obs_last_q[$];
    logic        obs_lib_q[$];

    keccak_padder #(.W(64), .RATE_LANES(17), .LEN_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .msg_len           (msg_len),
        .mode              (mode),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last_in_block (out_last_in_block),
        .out_last          (out_last),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane_val(input logic [63:0] base, input logic [63:0] step, input int k);
        return base + step * 64'(k);
    endfunction

    // Reference: whole padded byte stream, then sliced into little-endian lanes.
    task automatic build_exp(input int len, input logic [7:0] sfx, input logic [63:0] base, input logic [63:0] step);
        int total;
        logic [7:0] bytes[];
        total = (len / 136 + 1) * 136;
        bytes = new[total];
        for (int i = 0; i < total; i++) bytes[i] = 8'h00;
        for (int i = 0; i < len; i++) begin
            logic [63:0] l;
            l = lane_val(base, step, i / 8);
            bytes[i] = l[8*(i%8) +: 8];
        end
        bytes[len] = sfx;
        bytes[total-1] = bytes[total-1] | 8'h80;
        exp_q.delete();
        for (int k = 0; k < total / 8; k++) begin
            logic [63:0] v;
            for (int j = 0; j < 8; j++) v[8*j +: 8] = bytes[8*k + j];
            exp_q.push_back(v);
        end
    endtask

    task automatic run_msg(input int len, input logic [1:0] md, input logic [7:0] sfx,
                           input logic [63:0] base, input logic [63:0] step,
                           input bit toggle, input int abort_after);
        int n_in;
        int cyc;
        bit done;
        bit stalled;
        logic [63:0] held;
        n_in = (len + 7) / 8;
        cyc = 0;
        done = 1'b0;
        stalled = 1'b0;
        held = '0;
        build_exp(len, sfx, base, step);
        obs_q.delete();
        obs_last_q.delete();
        obs_lib_q.delete();
        n_consumed = 0;

        start = 1'b1;
        msg_len = 32'(len);
        mode = md;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);

        while (!done && cyc < 400) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            in_valid = 1'b1;
            in_data = lane_val(base, step, n_consumed);
            #1;
            if (stalled) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, held);
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (stalled) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) n_consumed++;
            if (out_valid && out_ready) begin
                obs_q.push_back(out_data);
                obs_last_q.push_back(out_last);
                obs_lib_q.push_back(out_last_in_block);
                if (out_last) done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (abort_after > 0 && obs_q.size() == abort_after) begin
                rst = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_in_ready", 64'(in_ready), 64'd0);
                check("rst_out_data", out_data, 64'd0);
                return;
            end
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        check("timeout", 64'(done), 64'd1);
        check("busy_fall", 64'(busy), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("lanes_in", 64'(n_consumed), 64'(n_in));
        check("lanes_out", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            check($sformatf("lane%0d_data", k), obs_q[k], exp_q[k]);
            check($sformatf("lane%0d_last", k), 64'(obs_last_q[k]), 64'(k == exp_q.size() - 1));
            check($sformatf("lane%0d_lib", k), 64'(obs_lib_q[k]), 64'(k % 17 == 16));
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        msg_len = '0;
        mode = '0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
        check("reset_out_lib", 64'(out_last_in_block), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Empty message: pure padding block.
        run_msg(0, 2'd1, 8'h06, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b0, 0);
        check("s1_lane0", obs_q[0], 64'h0000000000000006);
        for (int k = 1; k < 16; k++) check($sformatf("s1_zero%0d", k), obs_q[k], 64'd0);
        check("s1_lane16", obs_q[16], 64'h8000000000000000);
        check("s1_last16", 64'(obs_last_q[16]), 64'd1);

        // Three bytes: upper input bytes must be discarded.
        run_msg(3, 2'd1, 8'h06, 64'hFFFFFFFFFFCCBBAA, 64'd0, 1'b0, 0);
        check("s2_lane0", obs_q[0], 64'h0000000006CCBBAA);
        check("s2_lane16", obs_q[16], 64'h8000000000000000);

        // One byte short of a block: suffix and pad bit share the top byte.
        run_msg(135, 2'd1, 8'h06, 64'h1111111111111111, 64'd0, 1'b0, 0);
        check("s3_lane16", obs_q[16], 64'h8611111111111111);
        check("s3_count", 64'(obs_q.size()), 64'd17);

        // Exactly one block: a whole extra padding block follows.
        run_msg(136, 2'd2, 8'h1F, 64'h0706050403020100, 64'h0808080808080808, 1'b0, 0);
        check("s4_count", 64'(obs_q.size()), 64'd34);
        check("s4_in", 64'(n_consumed), 64'd17);
        check("s4_lane16", obs_q[16], 64'h8786858483828180);
        check("s4_lane17", obs_q[17], 64'h000000000000001F);
        check("s4_lane33", obs_q[33], 64'h8000000000000000);
        check("s4_lib16", 64'(obs_lib_q[16]), 64'd1);
        check("s4_lib33", 64'(obs_lib_q[33]), 64'd1);
        check("s4_last16", 64'(obs_last_q[16]), 64'd0);

        // Backpressure with out_ready toggling every cycle.
        run_msg(16, 2'd1, 8'h06, 64'h0706050403020100, 64'h0808080808080808, 1'b1, 0);
        check("s5_lane1", obs_q[1], 64'h0F0E0D0C0B0A0908);
        check("s5_lane2", obs_q[2], 64'h0000000000000006);

        // Keccak domain and the reserved mode encoding.
        run_msg(7, 2'd0, 8'h01, 64'hA7A6A5A4A3A2A1A0, 64'd0, 1'b0, 0);
        check("s6_lane0", obs_q[0], 64'h01A6A5A4A3A2A1A0);
        run_msg(8, 2'd3, 8'h06, 64'hB7B6B5B4B3B2B1B0, 64'd0, 1'b1, 0);
        check("s7_lane1", obs_q[1], 64'h0000000000000006);

        // Reset in the middle of a 100-byte message, then an empty message.
        run_msg(100, 2'd1, 8'h06, 64'h0706050403020100, 64'h0808080808080808, 1'b0, 5);
        @(posedge clk); #1;
        run_msg(0, 2'd1, 8'h06, 64'd0, 64'd0, 1'b0, 0);
        check("s8_lane0", obs_q[0], 64'h0000000000000006);
        check("s8_lane16", obs_q[16], 64'h8000000000000000);
        check("s8_count", 64'(obs_q.size()), 64'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
